// File: rtl/fp20_pkg.sv
// Shared format constants, operand classes and the classifier for the 20-bit float
// (sign[19], exponent[18:13] biased by 31, fraction[12:0] with hidden leading 1).
package fp20_pkg;
    localparam int EXP_W   = 6;
    localparam int FRAC_W  = 13;
    localparam int WIDTH   = 1 + EXP_W + FRAC_W;
    localparam int MANT_W  = FRAC_W + 1;
    localparam int PROD_W  = 2 * MANT_W;
    localparam int BIAS    = 31;
    localparam int EXP_MAX = 63;
    localparam logic [WIDTH-1:0] QNAN = 20'h7F000;

    typedef logic signed [7:0] exp_t;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    // Denormals have exponent 0 and are treated as zero.
    function automatic fp_class_e classify(input logic [WIDTH-1:0] x);
        logic [EXP_W-1:0]  e;
        logic [FRAC_W-1:0] f;
        e = x[WIDTH-2 -: EXP_W];
        f = x[FRAC_W-1:0];
        if (e == '0)
            return CLS_ZERO;
        if (e == '1)
            return (f == '0) ? CLS_INF : CLS_NAN;
        return CLS_NORM;
    endfunction
endpackage

// File: rtl/fp20_norm_round.sv
// Normalizes the 28-bit mantissa product and rounds to nearest, ties to even.
// exp_out includes the normalization shift only; the caller adds round_carry.
module fp20_norm_round
    import fp20_pkg::*;
(
    input  logic [PROD_W-1:0] prod,
    input  exp_t              exp_in,
    output logic [FRAC_W-1:0] frac,
    output exp_t              exp_out,
    output logic              round_carry
);
    logic [FRAC_W-1:0] frac_t;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [FRAC_W:0]   frac_r;

    // NOTE: every output of a combinational block is assigned on all paths, so no latch is inferred.
    always_comb begin
        if (prod[PROD_W-1]) begin
            frac_t  = prod[PROD_W-2 -: FRAC_W];
            guard   = prod[PROD_W-2-FRAC_W];
            sticky  = |prod[PROD_W-3-FRAC_W:0];
            exp_out = exp_in + 8'sd1;
        end else begin
            frac_t  = prod[PROD_W-3 -: FRAC_W];
            guard   = prod[PROD_W-3-FRAC_W];
            sticky  = |prod[PROD_W-4-FRAC_W:0];
            exp_out = exp_in;
        end
        round_up    = guard & (sticky | frac_t[0]);
        // An all-ones fraction rounding up wraps to zero, which is exactly 1.0 after renormalizing.
        frac_r      = {1'b0, frac_t} + {{FRAC_W{1'b0}}, round_up};
        frac        = frac_r[FRAC_W-1:0];
        round_carry = frac_r[FRAC_W];
    end
endmodule

// File: rtl/fp20_mul_pipe.sv
// Four-stage pipelined fp20 multiplier: capture, exponent/mantissa product,
// normalize/round, special-case packing into the output registers.
module fp20_mul_pipe
    import fp20_pkg::*;
(
    input  logic             clk,
    input  logic             sclr,
    input  logic             operation_nd,
    output logic             operation_rfd,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             rdy,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             underflow,
    output logic             invalid_op
);
    logic              accept;
    logic [2:0]        vld_q;

    logic [WIDTH-1:0]  a1_q, b1_q;

    fp_class_e         cls_a2_q, cls_b2_q;
    logic              sign2_q;
    exp_t              exp2_q;
    logic [PROD_W-1:0] prod2_q;

    fp_class_e         cls_a3_q, cls_b3_q;
    logic              sign3_q;
    exp_t              exp3_q;
    logic [FRAC_W-1:0] frac3_q;

    logic [FRAC_W-1:0] nr_frac;
    exp_t              nr_exp;
    logic              nr_carry;

    logic [WIDTH-1:0]  res_d;
    logic              ovf_d, unf_d, inv_d;

    assign accept = operation_nd & operation_rfd;

    // NOTE: sequential state uses non-blocking assignments so every stage sees last cycle's values.
    always_ff @(posedge clk) begin
        if (sclr) begin
            operation_rfd <= 1'b0;
            vld_q         <= '0;
            rdy           <= 1'b0;
            result        <= '0;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
            invalid_op    <= 1'b0;
        end else begin
            operation_rfd <= 1'b1;
            vld_q         <= {vld_q[1:0], accept};
            rdy           <= vld_q[2];
            if (vld_q[2]) begin
                result     <= res_d;
                overflow   <= ovf_d;
                underflow  <= unf_d;
                invalid_op <= inv_d;
            end
        end
    end

    // NOTE: datapath stages are not reset; the cleared valid chain keeps stale contents from escaping.
    always_ff @(posedge clk) begin
        if (accept) begin
            a1_q <= a;
            b1_q <= b;
        end
        if (vld_q[0]) begin
            cls_a2_q <= classify(a1_q);
            cls_b2_q <= classify(b1_q);
            sign2_q  <= a1_q[WIDTH-1] ^ b1_q[WIDTH-1];
            exp2_q   <= $signed({2'b00, a1_q[WIDTH-2 -: EXP_W]})
                      + $signed({2'b00, b1_q[WIDTH-2 -: EXP_W]}) - exp_t'(BIAS);
            prod2_q  <= PROD_W'({1'b1, a1_q[FRAC_W-1:0]}) * PROD_W'({1'b1, b1_q[FRAC_W-1:0]});
        end
        if (vld_q[1]) begin
            cls_a3_q <= cls_a2_q;
            cls_b3_q <= cls_b2_q;
            sign3_q  <= sign2_q;
            exp3_q   <= nr_exp + exp_t'(nr_carry);
            frac3_q  <= nr_frac;
        end
    end

    fp20_norm_round u_norm_round (
        .prod        (prod2_q),
        .exp_in      (exp2_q),
        .frac        (nr_frac),
        .exp_out     (nr_exp),
        .round_carry (nr_carry)
    );

    // Special cases in priority order; flags are mutually exclusive.
    always_comb begin
        res_d = {sign3_q, exp3_q[EXP_W-1:0], frac3_q};
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inv_d = 1'b0;
        if (cls_a3_q == CLS_NAN || cls_b3_q == CLS_NAN
            || (cls_a3_q == CLS_INF && cls_b3_q == CLS_ZERO)
            || (cls_a3_q == CLS_ZERO && cls_b3_q == CLS_INF)) begin
            res_d = QNAN;
            inv_d = 1'b1;
        end else if (cls_a3_q == CLS_INF || cls_b3_q == CLS_INF) begin
            res_d = {sign3_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (cls_a3_q == CLS_ZERO || cls_b3_q == CLS_ZERO) begin
            res_d = {sign3_q, {(WIDTH-1){1'b0}}};
        end else if (exp3_q >= exp_t'(EXP_MAX)) begin
            res_d = {sign3_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            ovf_d = 1'b1;
        end else if (exp3_q <= 8'sd0) begin
            res_d = {sign3_q, {(WIDTH-1){1'b0}}};
            unf_d = 1'b1;
        end
    end
endmodule

// File: tb/tb_fp20_mul_pipe.sv
// Self-checking bench for fp20_mul_pipe: directed vectors, a burst, random operands
// against an integer-arithmetic reference model, and reset while operands are in flight.
module tb_fp20_mul_pipe;
    logic        clk = 1'b0;
    logic        sclr;
    logic        operation_nd;
    logic        operation_rfd;
    logic [19:0] a, b;
    logic        rdy;
    logic [19:0] result;
    logic        overflow, underflow, invalid_op;

    logic [4:0]  free_cnt = 5'd0;

    typedef struct {
        int          due;
        logic [22:0] word;   // {overflow, underflow, invalid_op, result}
        logic [4:0]  cnt;
    } pend_t;

    pend_t pend_q[$];
    int    checks  = 0;
    int    errors  = 0;
    int    cyc     = 0;
    int    run_len = 0;
    int    max_run = 0;

    always #5 clk = ~clk;
    always @(posedge clk) free_cnt <= free_cnt + 5'd1;

    fp20_mul_pipe dut (
        .clk           (clk),
        .sclr          (sclr),
        .operation_nd  (operation_nd),
        .operation_rfd (operation_rfd),
        .a             (a),
        .b             (b),
        .rdy           (rdy),
        .result        (result),
        .overflow      (overflow),
        .underflow     (underflow),
        .invalid_op    (invalid_op)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    // Reference: exact integer product of the significands, then scaled and rounded.
    function automatic logic [22:0] ref_mul(input logic [19:0] x, input logic [19:0] y);
        int     ex, ey, e, sh;
        longint fx, fy, p, q, rem, half;
        logic   s, zx, zy, ix, iy, nx, ny;
        ex = int'(x[18:13]);  ey = int'(y[18:13]);
        fx = longint'(x[12:0]); fy = longint'(y[12:0]);
        s  = x[19] ^ y[19];
        zx = (ex == 0);  zy = (ey == 0);
        ix = (ex == 63) && (fx == 0);  iy = (ey == 63) && (fy == 0);
        nx = (ex == 63) && (fx != 0);  ny = (ey == 63) && (fy != 0);
        if (nx || ny || (ix && zy) || (iy && zx)) return {3'b001, 20'h7F000};
        if (ix || iy) return {3'b000, s, 6'h3F, 13'h0};
        if (zx || zy) return {3'b000, s, 19'h0};
        p    = (8192 + fx) * (8192 + fy);
        sh   = (p >= 64'd134217728) ? 14 : 13;
        e    = ex + ey - 31 + (sh - 13);
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == 16384) begin
            q = 8192;
            e = e + 1;
        end
        if (e >= 63) return {3'b100, s, 6'h3F, 13'h0};
        if (e <= 0)  return {3'b010, s, 19'h0};
        return {3'b000, s, 6'(e), 13'(q)};
    endfunction

    function automatic logic [19:0] gen_op();
        logic [5:0]  e;
        logic [12:0] f;
        logic        s;
        s = 1'($urandom_range(0, 1));
        f = 13'($urandom());
        case ($urandom_range(0, 9))
            0:       e = 6'h00;
            1: begin
                e = 6'h3F;
                if ($urandom_range(0, 1) == 1) f = '0;
            end
            2:       e = 6'($urandom_range(1, 62));
            default: e = 6'($urandom_range(16, 46));
        endcase
        return {s, e, f};
    endfunction

    task automatic tick();
        pend_t p;
        @(posedge clk);
        #1;
        cyc++;
        if (rdy === 1'b1) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        if (sclr) begin
            pend_q.delete();
            check("reset_rdy", 32'(rdy), 32'd0);
            check("reset_rfd", 32'(operation_rfd), 32'd0);
            check("reset_out", 32'({overflow, underflow, invalid_op, result}), 32'd0);
        end else begin
            check("rfd", 32'(operation_rfd), 32'd1);
            if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                p = pend_q.pop_front();
                check("rdy", 32'(rdy), 32'd1);
                check("product", 32'({overflow, underflow, invalid_op, result}), 32'(p.word));
                check("latency_cnt", 32'(5'(free_cnt - p.cnt)), 32'd4);
            end else begin
                check("rdy_idle", 32'(rdy), 32'd0);
            end
        end
    endtask

    task automatic issue(input logic [19:0] x, input logic [19:0] y, input logic [22:0] word);
        pend_t p;
        a = x;
        b = y;
        operation_nd = 1'b1;
        p.due  = cyc + 4;
        p.word = word;
        p.cnt  = free_cnt;
        pend_q.push_back(p);
        tick();
        operation_nd = 1'b0;
    endtask

    logic [19:0] da [11] = '{20'h3E000, 20'h3F000, 20'hC0000, 20'h3E001, 20'h3FFFF, 20'h7C000,
                             20'h02000, 20'h7E000, 20'h7E001, 20'hFE000, 20'h80000};
    logic [19:0] db [11] = '{20'h40000, 20'h3F000, 20'h3F000, 20'h3E001, 20'h3E001, 20'h7C000,
                             20'h02000, 20'h00000, 20'h3E000, 20'h3E000, 20'h3E000};
    logic [22:0] dw [11] = '{23'h040000, 23'h040400, 23'h0C1000, 23'h03E002, 23'h040000, 23'h47E000,
                             23'h200000, 23'h17F000, 23'h17F000, 23'h0FE000, 23'h080000};

    initial begin
        logic [19:0] x, y;
        sclr = 1'b1;
        operation_nd = 1'b0;
        a = '0;
        b = '0;
        repeat (2) tick();
        sclr = 1'b0;
        tick();

        issue(da[0], db[0], dw[0]);
        repeat (6) tick();
        for (int i = 1; i < 11; i++) issue(da[i], db[i], dw[i]);
        repeat (6) tick();

        max_run = 0;
        for (int i = 0; i < 16; i++) begin
            x = 20'h3C000 + 20'(i) * 20'h01000;
            issue(x, x, ref_mul(x, x));
        end
        repeat (6) tick();
        check("burst_len", 32'(max_run), 32'd16);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                x = gen_op();
                y = gen_op();
                issue(x, y, ref_mul(x, y));
            end else begin
                tick();
            end
        end
        repeat (6) tick();

        for (int i = 0; i < 3; i++) begin
            x = gen_op();
            y = gen_op();
            issue(x, y, ref_mul(x, y));
        end
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        a = 20'h3F000;
        b = 20'h3F000;
        operation_nd = 1'b1;
        tick();
        operation_nd = 1'b0;
        issue(20'h3E000, 20'h40000, 23'h040000);
        repeat (8) tick();

        check("drain", 32'(pend_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
